// File: rtl/seg7_scan_display_pkg.sv
// Shared definitions for the 7-segment scan display slice.
//  - NUM_DIGITS / IDX_W : number of scanned digits and width of the digit index
//  - bcd_t              : one BCD digit
//  - SEG_*              : active-high segment patterns, bit order {g,f,e,d,c,b,a}
package seg7_scan_display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = 2;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_scan_display_bcd_seg7_decoder.sv
// Combinational BCD to 7-segment decoder.
//  - bcd : input digit (0-9 valid)
//  - seg : active-high segments {g,f,e,d,c,b,a}; codes 10-15 show a dash
module bcd_seg7_decoder
    import seg7_scan_display_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed 7-segment driver with double-buffered digit data,
// leading-zero blanking, per-digit decimal points and 8-step PWM brightness.
//  - clk, reset : system clock, synchronous active-high reset
//  - digits_in  : {d3,d2,d1,d0} BCD, captured into the pending buffer on load
//  - load       : one-cycle capture strobe
//  - dp_mask    : decimal point enable per digit (live)
//  - blank_lz   : blank leading zeros (live)
//  - duty       : brightness, lit for (duty+1)/8 of each digit slot (live)
//  - seg, dp, an: registered segment bus, decimal point, one-hot digit enables
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int SCAN_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           digits_in,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  blank_lz,
    input  logic [2:0]            duty,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);

    logic [SCAN_LOG2-1:0]  slot_cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [15:0]           pending_reg;
    logic [15:0]           active_reg;
    logic [6:0]            seg_reg;
    logic                  dp_reg;
    logic [NUM_DIGITS-1:0] an_reg;

    bcd_t                  active_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_zero;
    logic [NUM_DIGITS-1:0] blank_run;

    // blank_run[k]: digit k and everything above it is zero. Digit 0 is
    // never blanked so a value of 0000 still shows a single "0".
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign active_digit[gi] = active_reg[4*gi +: 4];
            assign digit_zero[gi]   = (active_reg[4*gi +: 4] == 4'd0);
            if (gi == 0) begin : g_lsd
                assign blank_run[gi] = 1'b0;
            end else begin : g_upper
                assign blank_run[gi] = &digit_zero[NUM_DIGITS-1:gi];
            end
        end
    endgenerate

    bcd_t       cur_digit;
    logic [6:0] dec_seg;
    logic [2:0] phase;
    logic       lit;
    logic       cur_blank;
    logic       slot_wrap;
    logic       frame_end;

    assign cur_digit = active_digit[idx_reg];

    bcd_seg7_decoder u_decoder (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // PWM phase is the top three bits of the slot counter, so each slot is
    // split into eight equal sub-periods regardless of SCAN_LOG2.
    assign phase     = slot_cnt_reg[SCAN_LOG2-1 -: 3];
    assign lit       = (phase <= duty);
    assign cur_blank = blank_lz & blank_run[idx_reg];
    assign slot_wrap = &slot_cnt_reg;
    assign frame_end = slot_wrap && (idx_reg == IDX_W'(NUM_DIGITS - 1));

    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    always_comb begin
        seg_next = SEG_OFF;
        dp_next  = 1'b0;
        an_next  = '0;
        if (lit) begin
            seg_next = cur_blank ? SEG_OFF : dec_seg;
            dp_next  = dp_mask[idx_reg];
            an_next  = NUM_DIGITS'(1) << idx_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_reg <= '0;
            idx_reg      <= '0;
            pending_reg  <= '0;
            active_reg   <= '0;
            seg_reg      <= SEG_OFF;
            dp_reg       <= 1'b0;
            an_reg       <= '0;
        end else begin
            slot_cnt_reg <= slot_cnt_reg + 1'b1;
            if (slot_wrap) begin
                idx_reg <= idx_reg + 1'b1;
            end
            if (load) begin
                pending_reg <= digits_in;
            end
            // A load landing on the boundary bypasses pending so it is not
            // delayed by a whole frame.
            if (frame_end) begin
                active_reg <= load ? digits_in : pending_reg;
            end
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;
    assign an  = an_reg;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with SCAN_LOG2=3 (8-clk slots,
// 32-clk frames). Expected segment patterns are hand-decoded per frame.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic [2:0]  duty;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    always #5 clk = ~clk;

    seg7_scan_display #(.SCAN_LOG2(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .digits_in (digits_in),
        .load      (load),
        .dp_mask   (dp_mask),
        .blank_lz  (blank_lz),
        .duty      (duty),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    int          errors   = 0;
    int          checks   = 0;
    int          cyc      = 0;
    int          load_c   = -1;
    logic [15:0] load_val = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: present load for the cycle whose pre-edge count is load_c,
    // then sample 1 time unit after the edge.
    task automatic step();
        load      = (cyc == load_c);
        digits_in = load_val;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_slot(input string tag, input logic [6:0] exp_seg,
                            input logic exp_dp, input int dty);
        int idx;
        int lit_n;
        bit lit;
        idx   = (cyc / 8) % 4;
        lit_n = 0;
        for (int p = 0; p < 8; p++) begin
            lit = (p <= dty);
            step();
            chk({tag, "/an"},  32'(an),  lit ? (32'd1 << idx) : 32'd0);
            chk({tag, "/seg"}, 32'(seg), lit ? 32'(exp_seg) : 32'd0);
            chk({tag, "/dp"},  32'(dp),  lit ? 32'(exp_dp) : 32'd0);
            chk({tag, "/onehot"}, 32'($countones(an) > 1), 32'd0);
            if (an != 4'd0) lit_n++;
        end
        chk({tag, "/litcnt"}, 32'(lit_n), 32'(dty + 1));
        $display("slot %s digit=%0d exp_seg=%02h exp_dp=%0d duty=%0d lit=%0d", tag, idx, exp_seg, exp_dp, dty, lit_n);
    endtask

    task automatic run_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic [3:0] dpm, input int dty);
        run_slot({tag, ".d0"}, s0, dpm[0], dty);
        run_slot({tag, ".d1"}, s1, dpm[1], dty);
        run_slot({tag, ".d2"}, s2, dpm[2], dty);
        run_slot({tag, ".d3"}, s3, dpm[3], dty);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0000;
        dp_mask   = 4'b0000;
        blank_lz  = 1'b0;
        duty      = 3'd7;

        // Reset held two clocks: outputs all zero.
        step();
        chk("rst1/seg", 32'(seg), 32'd0);
        chk("rst1/dp",  32'(dp),  32'd0);
        chk("rst1/an",  32'(an),  32'd0);
        step();
        chk("rst2/seg", 32'(seg), 32'd0);
        chk("rst2/dp",  32'(dp),  32'd0);
        chk("rst2/an",  32'(an),  32'd0);
        reset = 1'b0;
        cyc   = 0;

        // Frame 0 shows zeros; a mid-frame load of 1234 waits for frame 1.
        load_c = 5;  load_val = 16'h1234;
        run_frame("f0", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, 7);

        // Frame 1 shows 1234; 0987 loaded exactly on the frame boundary.
        load_c = 63; load_val = 16'h0987;
        run_frame("f1", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0000, 7);

        // Frame 2 shows 0987 with leading zero blanked; 000A loaded mid-frame.
        blank_lz = 1'b1;
        load_c = 80; load_val = 16'h000A;
        run_frame("f2", 7'h00, 7'h6F, 7'h7F, 7'h07, 4'b0000, 7);

        // Frame 3: dash on d0, upper digits blanked, dp on d2 survives blanking.
        dp_mask = 4'b0100;
        run_frame("f3", 7'h00, 7'h00, 7'h00, 7'h40, 4'b0100, 7);

        // Frame 4: PWM duty=2; 0B56 loaded mid-frame.
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;
        duty     = 3'd2;
        load_c = 140; load_val = 16'h0B56;
        run_frame("f4", 7'h3F, 7'h3F, 7'h3F, 7'h40, 4'b0000, 2);

        // Frame 5: non-BCD digit stops blanking at d2; all dps lit.
        duty     = 3'd7;
        blank_lz = 1'b1;
        dp_mask  = 4'b1111;
        run_frame("f5", 7'h00, 7'h40, 7'h6D, 7'h7D, 4'b1111, 7);

        // Reset mid-frame with a pending load of 5555.
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;
        load_c = 197; load_val = 16'h5555;
        repeat (10) step();
        reset = 1'b1;
        step();
        chk("mrst1/an",  32'(an),  32'd0);
        chk("mrst1/seg", 32'(seg), 32'd0);
        step();
        chk("mrst2/an",  32'(an),  32'd0);
        chk("mrst2/dp",  32'(dp),  32'd0);
        reset  = 1'b0;
        cyc    = 0;
        load_c = -1;

        // Display restarts at digit 0 with zeros; pending 5555 must not appear.
        run_frame("r0", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, 7);
        run_frame("r1", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
